lzc_bitmap_builder: RTL and testbench

// - Inverse side of the leading-zero-count (LZC) encoder. Accepts a stream of LZC codes over valid/ready.
// - Decodes each code back to the one-hot bit it names and ORs it into an accumulator.
// - On the beat flagged last, emits the rebuilt DATA_W-bit bitmap with beat count and duplicate flag.
// - Sits downstream of the LZC encoder; rebuilds set-bit masks from per-bit position reports.

---
 rtl/lzc_bitmap_builder_pkg.sv | 20 ++
 rtl/lzc_bitmap_builder_decode.sv | 36 +++
 rtl/lzc_bitmap_builder.sv | 131 +++++++++++++
 tb/tb_lzc_bitmap_builder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_bitmap_builder_pkg.sv
// ---------------------------------------------------------------------------
// lzc_bitmap_builder_pkg
// Constants and types shared by the LZC encoder and its consumers.
//   LZC_DATA_W : bitmap width covered by one LZC code stream.
//   LZC_CODE_W : code width. The MSB flags an all-zero word. The low bits
//                carry the leading-zero count.
//   lzc_state_e: bitmap builder FSM states.
// ---------------------------------------------------------------------------
package lzc_bitmap_builder_pkg;

  localparam int LZC_DATA_W = 32;
  localparam int LZC_CODE_W = $clog2(LZC_DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } lzc_state_e;

endpackage : lzc_bitmap_builder_pkg

// File: rtl/lzc_bitmap_builder_decode.sv
// ---------------------------------------------------------------------------
// lzc_decode
// Combinational decoder from an LZC code to the one-hot bit it names.
//   code_i   [CODE_W-1:0] : LZC code. MSB=1 means a zero word.
//   onehot_o [DATA_W-1:0] : one-hot of bit (DATA_W-1 - lzc). It is all-zero
//                           when the code MSB is set.
// When the MSB is set, the low bits are ignored, even when they are non-zero.
// ---------------------------------------------------------------------------
module lzc_decode
  import lzc_bitmap_builder_pkg::*;
#(
  parameter  int DATA_W = LZC_DATA_W,
  localparam int CODE_W = $clog2(DATA_W) + 1
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [DATA_W-1:0] onehot_o
);

  localparam int LZ_W = CODE_W - 1;

  logic              zero_word;
  logic [LZ_W-1:0]   lz;

  assign zero_word = code_i[CODE_W-1];
  assign lz        = code_i[LZ_W-1:0];

  // Bit i is selected when the leading-zero count equals DATA_W-1-i.
  // DATA_W is a power of two, so every lz value maps to a real bit.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      onehot_o[i] = ~zero_word && (lz == LZ_W'(DATA_W - 1 - i));
    end
  end

endmodule : lzc_decode

// File: rtl/lzc_bitmap_builder.sv
// ---------------------------------------------------------------------------
// lzc_bitmap_builder
// Rebuilds a DATA_W-bit set-bit mask from a stream of LZC position codes.
// Each accepted code is decoded to one bit and ORed into an accumulator.
// The beat flagged last completes the bitmap. The bitmap is then held on the
// map_* outputs until the downstream side accepts it.
//   clk, rst_n             : clock and asynchronous active-low reset
//   code_valid/code_ready  : input handshake. code_ready depends only on state.
//   code, code_last        : LZC code and end-of-bitmap flag
//   map_valid/map_ready    : output handshake
//   map_data               : rebuilt bitmap
//   map_count              : accepted beats for this bitmap. Saturates at
//                            2^CODE_W-1.
//   map_dup                : a non-zero-word code hit a bit that was already set
// All outputs are driven directly from registers.
// ---------------------------------------------------------------------------
module lzc_bitmap_builder
  import lzc_bitmap_builder_pkg::*;
#(
  parameter  int DATA_W = LZC_DATA_W,
  localparam int CODE_W = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code,
  input  logic              code_last,
  output logic              map_valid,
  input  logic              map_ready,
  output logic [DATA_W-1:0] map_data,
  output logic [CODE_W-1:0] map_count,
  output logic              map_dup
);

  // Beat counter with saturation at all-ones.
  function automatic logic [CODE_W-1:0] sat_inc(input logic [CODE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  lzc_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CODE_W-1:0] cnt_q, cnt_d;
  logic              dup_q, dup_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] dec_onehot;
  logic              accept;

  lzc_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .code_i   (code),
    .onehot_o (dec_onehot)
  );

  assign accept = code_valid && ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dup_d   = dup_q;
    case (state_q)
      ST_IDLE: begin
        // The accumulator is already empty, so the first beat simply loads.
        if (accept) begin
          acc_d   = dec_onehot;
          cnt_d   = CODE_W'(1);
          dup_d   = 1'b0;
          state_d = code_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d   = acc_q | dec_onehot;
          cnt_d   = sat_inc(cnt_q);
          // A zero-word code decodes to all-zero and can never flag dup.
          dup_d   = dup_q | (|(acc_q & dec_onehot));
          state_d = code_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (map_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          dup_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        dup_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // Handshake flags come from the next state. Both flags are then
    // registered, so there is no combinational path from map_ready to
    // code_ready.
    ready_d = (state_d != ST_HOLD);
    valid_d = (state_d == ST_HOLD);
  end

  // ready_q resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign code_ready = ready_q;
  assign map_valid  = valid_q;
  assign map_data   = acc_q;
  assign map_count  = cnt_q;
  assign map_dup    = dup_q;

endmodule : lzc_bitmap_builder

// File: tb/tb_lzc_bitmap_builder.sv
module tb_lzc_bitmap_builder;

  logic        clk;
  logic        rst_n;
  logic        code_valid;
  logic        code_ready;
  logic [5:0]  code;
  logic        code_last;
  logic        map_valid;
  logic        map_ready;
  logic [31:0] map_data;
  logic [5:0]  map_count;
  logic        map_dup;

  int total = 0;
  int bad   = 0;

  lzc_bitmap_builder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .code_last  (code_last),
    .map_valid  (map_valid),
    .map_ready  (map_ready),
    .map_data   (map_data),
    .map_count  (map_count),
    .map_dup    (map_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a code below 32 names bit 31-code. Codes 32..63 are zero words.
  function automatic void model(input logic [5:0] codes[$], output logic [31:0] m,
                                output logic [5:0] c, output logic d);
    m = 32'd0;
    d = 1'b0;
    for (int i = 0; i < codes.size(); i++) begin
      if (codes[i] < 6'd32) begin
        int pos;
        pos = 31 - int'(codes[i]);
        if (m[pos]) d = 1'b1;
        m[pos] = 1'b1;
      end
    end
    c = (codes.size() > 63) ? 6'd63 : 6'(codes.size());
  endfunction

  // Offer each code in turn. The last one carries code_last.
  // On return the last beat was accepted at the previous edge.
  task automatic drive_beats(input logic [5:0] codes[$], input bit gaps);
    int n;
    for (int i = 0; i < codes.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        code_valid = 1'b0;
        @(posedge clk); #1;
      end
      code_valid = 1'b1;
      code       = codes[i];
      code_last  = (i == codes.size() - 1);
      n = 0;
      while (code_ready !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) begin
        total++; bad++;
        $display("FAIL drive_timeout: code_ready=%b required 1 within 100 cycles", code_ready);
        code_valid = 1'b0;
        code_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    code_valid = 1'b0;
    code_last  = 1'b0;
  endtask

  // Wait for map_valid, sample the map_* outputs, then complete one handshake.
  task automatic collect(output logic [31:0] d, output logic [5:0] c, output logic u);
    int n;
    n = 0;
    while (map_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL collect_timeout: map_valid=%b required 1 within 50 cycles", map_valid);
    end
    d = map_data;
    c = map_count;
    u = map_dup;
    map_ready = 1'b1;
    @(posedge clk); #1;
    map_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; code_valid = 1'b0; code = '0; code_last = 1'b0; map_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({map_valid, code_ready, map_dup} !== 3'b000 || map_data !== 32'd0 || map_count !== 6'd0) begin
      bad++;
      $display("FAIL reset_outputs: valid/ready/dup=%b%b%b data=%h count=%0d required 000 0 0",
               map_valid, code_ready, map_dup, map_data, map_count);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (code_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_before_edge: code_ready=%b required 0", code_ready);
    end
    @(posedge clk); #1;
    total++;
    if (code_ready !== 1'b1 || map_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ready_after_edge: code_ready=%b map_valid=%b required 1 0",
                      code_ready, map_valid);
    end
  endtask

  task automatic test_basic();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    q = '{6'd0, 6'd31, 6'd15};
    drive_beats(q, 1'b0);
    total++;
    if (map_valid !== 1'b1 || code_ready !== 1'b0) begin
      bad++; $display("FAIL basic_latency: map_valid=%b code_ready=%b required 1 0", map_valid, code_ready);
    end
    collect(d, c, u);
    total++;
    if (d !== 32'h8001_0001 || c !== 6'd3 || u !== 1'b0) begin
      bad++; $display("FAIL basic_map: data=%h count=%0d dup=%b required 80010001 3 0", d, c, u);
    end
  endtask

  task automatic test_dup();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    q = '{6'd5, 6'd5};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'h0400_0000 || c !== 6'd2 || u !== 1'b1) begin
      bad++; $display("FAIL dup_map: data=%h count=%0d dup=%b required 04000000 2 1", d, c, u);
    end
  endtask

  task automatic test_zero_word();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    q = '{6'b100000};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'd0 || c !== 6'd1 || u !== 1'b0) begin
      bad++; $display("FAIL zero_word: data=%h count=%0d dup=%b required 0 1 0", d, c, u);
    end
    q = '{6'b101010};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'd0 || c !== 6'd1 || u !== 1'b0) begin
      bad++; $display("FAIL zero_word_illegal: data=%h count=%0d dup=%b required 0 1 0", d, c, u);
    end
    q = '{6'b111111, 6'b100001, 6'b100000};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'd0 || c !== 6'd3 || u !== 1'b0) begin
      bad++; $display("FAIL zero_word_multi: data=%h count=%0d dup=%b required 0 3 0", d, c, u);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    q = '{6'd3, 6'd9};
    drive_beats(q, 1'b0);
    code_valid = 1'b1; code = 6'd7; code_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (map_valid !== 1'b1 || code_ready !== 1'b0 || map_data !== 32'h1040_0000 ||
          map_count !== 6'd2 || map_dup !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b data=%h count=%0d dup=%b required 1 0 10400000 2 0",
                 k, map_valid, code_ready, map_data, map_count, map_dup);
      end
      @(posedge clk); #1;
    end
    code_valid = 1'b0; code_last = 1'b0;
    collect(d, c, u);
    total++;
    if (code_ready !== 1'b1 || map_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release: code_ready=%b map_valid=%b required 1 0", code_ready, map_valid);
    end
    q = '{6'd31};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'h0000_0001 || c !== 6'd1 || u !== 1'b0) begin
      bad++; $display("FAIL hold_not_consumed: data=%h count=%0d dup=%b required 00000001 1 0", d, c, u);
    end
  endtask

  task automatic test_saturation();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    q = {};
    for (int i = 0; i < 71; i++) q.push_back(6'd0);
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'h8000_0000 || c !== 6'd63 || u !== 1'b1) begin
      bad++; $display("FAIL saturation: data=%h count=%0d dup=%b required 80000000 63 1", d, c, u);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    code_valid = 1'b1; code = 6'd2; code_last = 1'b0;
    @(posedge clk); #1;
    code = 6'd4;
    @(posedge clk); #1;
    code_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (code_ready !== 1'b0 || map_data !== 32'd0 || map_count !== 6'd0) begin
      bad++; $display("FAIL reset_mid_async: ready=%b data=%h count=%0d required 0 0 0",
                      code_ready, map_data, map_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q = '{6'd31};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'h0000_0001 || c !== 6'd1 || u !== 1'b0) begin
      bad++; $display("FAIL reset_mid_map: data=%h count=%0d dup=%b required 00000001 1 0", d, c, u);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] q[$];
    logic [31:0] d; logic [5:0] c; logic u;
    q = '{6'd10, 6'd20};
    drive_beats(q, 1'b0);
    map_ready = 1'b1;
    @(posedge clk); #1;
    map_ready = 1'b0;
    total++;
    if (code_ready !== 1'b1 || map_valid !== 1'b0 || map_data !== 32'd0) begin
      bad++; $display("FAIL b2b_no_bubble: ready=%b valid=%b data=%h required 1 0 0",
                      code_ready, map_valid, map_data);
    end
    q = '{6'd1};
    drive_beats(q, 1'b0);
    collect(d, c, u);
    total++;
    if (d !== 32'h4000_0000 || c !== 6'd1 || u !== 1'b0) begin
      bad++; $display("FAIL b2b_next: data=%h count=%0d dup=%b required 40000000 1 0", d, c, u);
    end
  endtask

  task automatic test_random();
    logic [5:0] q[$];
    logic [31:0] d, em; logic [5:0] c, ec; logic u, eu;
    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(1, 12);
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) q.push_back(6'($urandom_range(0, 3)));
        else                           q.push_back(6'($urandom_range(0, 63)));
      end
      model(q, em, ec, eu);
      drive_beats(q, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      collect(d, c, u);
      total++;
      if (d !== em || c !== ec || u !== eu) begin
        bad++; $display("FAIL random[%0d]: data=%h count=%0d dup=%b required %h %0d %b",
                        t, d, c, u, em, ec, eu);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_zero_word();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lzc_bitmap_builder
